risc_controller: RTL and testbench
==================================

# risc_controller

Phase sequencer and control decoder for the lab RISC CPU. Steps an 8-phase instruction cycle. From the current phase, the opcode and the ALU zero flag it drives the control strobes for:
- the shared memory (`rd`, `wr`, address-mux `sel`);
- the instruction register, accumulator and program counter;
- the data-bus driver.

It sits directly upstream of the 32x8 memory and decides every read and write it performs.

## Interface

Parameters:
- `OPW`, 3, opcode width
- `PHW`, 3, phase counter width (8 phases)

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  OPW  instruction opcode from the instruction register
- `zero`  in  1  accumulator-is-zero flag from the ALU
- `sel`  out  1  address mux select: 1 = PC, 0 = IR operand field
- `rd`  out  1  memory read enable
- `wr`  out  1  memory write enable
- `ld_ir`  out  1  instruction register load
- `ld_ac`  out  1  accumulator load
- `inc_pc`  out  1  program counter increment
- `ld_pc`  out  1  program counter load (jump)
- `data_e`  out  1  bus driver enable (accumulator onto the memory data bus)
- `halt`  out  1  CPU halted
- `phase`  out  PHW  current phase, for debug and bench

## Operation

Opcodes:
- HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
- ALUOP = ADD | AND | XOR | LDA

State:
- 3-bit phase register, values 0–7: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- 1-bit `halted` register.

Phase advance:
- Phase increments by 1 each cycle and wraps 7 -> 0.
- When `halted` = 1, phase holds at 4 (OP_ADDR).

Control decode is combinational from `phase`, `opcode`, `zero` and `halted`. Any output not listed for a phase is 0 in that phase.
- 0 INST_ADDR: `sel`=1
- 1 INST_FETCH: `sel`=1, `rd`=1
- 2 INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1
- 3 IDLE: `sel`=1, `rd`=1, `ld_ir`=1
- 4 OP_ADDR: `inc_pc`=1, `halt`=(opcode==HLT)
- 5 OP_FETCH: `rd`=ALUOP
- 6 ALU_OP: `rd`=ALUOP, `inc_pc`=(SKZ & zero), `ld_pc`=JMP, `data_e`=STO
- 7 STORE: `rd`=ALUOP, `ld_ac`=ALUOP, `ld_pc`=JMP, `wr`=STO, `data_e`=STO

Halt:
- `halted` is set at the clock edge that ends phase 4 when opcode==HLT.
- While `halted`=1, `halt`=1 and every other strobe is 0, including `inc_pc`, so the PC stays frozen on the HLT address.
- Only `rst_n` clears `halted`.

Opcode sampling:
- `opcode` is only meaningful in phases 4–7; the IR is stable from the end of phase 3.
- In phases 0–3 the decode ignores `opcode` and `zero`.

Invariants:
- `wr` and `rd` are never 1 in the same cycle.
- `wr`=1 implies `data_e`=1.
- `data_e` leads `wr` by one cycle (phase 6), so bus data is settled before the memory's write edge.

## Timing

- Reset: asynchronous. While `rst_n`=0:
  - `phase`=0, `halted`=0
  - outputs show the phase-0 decode: `sel`=1, all other strobes 0, `halt`=0
- After the reset release edge: the first rising `clk` edge moves the phase to 1.
- Instruction cycle: exactly 8 clocks for every opcode; no stalls, no handshake.
- Memory read data appears on the bus one cycle after `rd` rises, because the memory registers its output. For that reason `rd` stays high across the consumer load phase: 2–3 for the IR, 6–7 for the ACC.
- Store: `wr`=1 in phase 7 only. The memory captures on the edge that ends phase 7.
- Skip: SKZ with `zero`=1 gives two PC increments in the cycle (phases 4 and 6). SKZ with `zero`=0 gives one.
- Jump: `ld_pc`=1 in phases 6 and 7 for JMP. The load overrides the phase-4 increment.
- Reset mid-cycle, in any phase or while halted: immediate return to phase 0 with `halted`=0.

## Test plan

- Reset then free run, `opcode`=ADD, `zero`=0 -> `phase` counts 0..7, 0..7. `sel`=1 in phases 0–3 only. `rd`=1 in phases 1,2,3,5,6,7. `ld_ac`=1 in phase 7 only. `wr` never 1.
- `opcode`=STO -> phase 6: `data_e`=1, `wr`=0. Phase 7: `wr`=1, `data_e`=1, `rd`=0. Every other phase: `wr`=0.
- `opcode`=SKZ with `zero`=1 -> `inc_pc`=1 in phases 4 and 6. Repeat with `zero`=0 -> `inc_pc`=1 in phase 4 only.
- `opcode`=JMP -> `ld_pc`=1 in phases 6 and 7. `rd`, `ld_ac` and `wr` all 0 in phases 5–7.
- `opcode`=HLT:
  - `halt`=1 in phase 4; phase then stays at 4 for 20 or more cycles.
  - `inc_pc`=0 after the halting cycle; all strobes except `halt` are 0.
  - Asserting `rst_n`=0 -> `phase`=0 and `halt`=0 immediately, without waiting for a clock edge.
- Assert `rst_n` asynchronously in phase 6 with `opcode`=STO -> `data_e` and `wr` drop to 0 at once. After release the cycle restarts at phase 0.

Source files
------------

// File: rtl/risc_controller.sv
// risc_controller: 8-phase instruction sequencer and control-strobe decoder
// for the lab RISC CPU. Drives memory, IR, ACC, PC and bus-driver strobes.
//
// phase | meaning
// ------+---------------------------------------------------------------
//   0   | INST_ADDR  - PC on the address mux
//   1   | INST_FETCH - read instruction word
//   2   | INST_LOAD  - registered memory data valid, load IR
//   3   | IDLE       - IR load held, opcode settles
//   4   | OP_ADDR    - operand address, PC increment, HLT detection
//   5   | OP_FETCH   - operand read for ALU ops
//   6   | ALU_OP     - skip / jump / bus driver precharge for store
//   7   | STORE      - ACC load, memory write, jump load
//  4*   | halted     - phase parked at OP_ADDR until reset

module risc_controller #(
    parameter int OPW = 3,
    parameter int PHW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           sel,
    output logic           rd,
    output logic           wr,
    output logic           ld_ir,
    output logic           ld_ac,
    output logic           inc_pc,
    output logic           ld_pc,
    output logic           data_e,
    output logic           halt,
    output logic [PHW-1:0] phase
);

    localparam logic [PHW-1:0] P_INST_ADDR  = PHW'(0);
    localparam logic [PHW-1:0] P_INST_FETCH = PHW'(1);
    localparam logic [PHW-1:0] P_INST_LOAD  = PHW'(2);
    localparam logic [PHW-1:0] P_IDLE       = PHW'(3);
    localparam logic [PHW-1:0] P_OP_ADDR    = PHW'(4);
    localparam logic [PHW-1:0] P_OP_FETCH   = PHW'(5);
    localparam logic [PHW-1:0] P_ALU_OP     = PHW'(6);
    localparam logic [PHW-1:0] P_STORE      = PHW'(7);

    localparam logic [OPW-1:0] OP_HLT = OPW'(0);
    localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_LDA = OPW'(5);
    localparam logic [OPW-1:0] OP_STO = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);

    logic [PHW-1:0] r_phase;
    logic           r_halted;

    logic w_halt_now;
    logic w_aluop;
    logic w_skz;
    logic w_sto;
    logic w_jmp;

    // Opcode class decode; only consulted in phases 4-7
    always_comb begin
        w_aluop    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
        w_skz      = (opcode == OP_SKZ);
        w_sto      = (opcode == OP_STO);
        w_jmp      = (opcode == OP_JMP);
        w_halt_now = !r_halted && (r_phase == P_OP_ADDR) && (opcode == OP_HLT);
    end

    // Phase counter and sticky halt; parked at OP_ADDR once HLT is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= P_INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            if (r_halted || w_halt_now) begin
                r_phase <= P_OP_ADDR;
            end else begin
                r_phase <= r_phase + PHW'(1);
            end
            if (w_halt_now) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Control strobe decode; halted suppresses everything except halt
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                P_INST_ADDR: begin
                    sel = 1'b1;
                end
                P_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                P_INST_LOAD, P_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                P_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                P_OP_FETCH: begin
                    rd = w_aluop;
                end
                P_ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = w_skz && zero;
                    ld_pc  = w_jmp;
                    data_e = w_sto;
                end
                P_STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = w_jmp;
                    wr     = w_sto;
                    data_e = w_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = r_phase;

endmodule

// File: tb/tb_risc_controller.sv
// Testbench for risc_controller: directed test-plan sequences followed by
// randomized opcode/zero/reset stimulus against a behavioural model.

module tb_risc_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
    logic [2:0] phase;

    int n_vec;
    int n_err;

    // behavioural model state
    int m_phase;
    bit m_halted;
    int m_halt_cnt;

    risc_controller #(.OPW(3), .PHW(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (model phase %0d, opcode %0d, zero %0b, halted %0b)",
                     tag, got, exp, m_phase, opcode, zero, m_halted);
        end
    endtask

    // Expected strobes {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt}
    function automatic logic [8:0] exp_ctrl(input int ph, input int op, input bit z, input bit hlt);
        bit aluop, act;
        logic [8:0] v;
        aluop = (op >= 2) && (op <= 5);
        act   = !hlt;
        v[8] = act && (ph < 4);
        v[7] = act && (((ph >= 1) && (ph <= 3)) || ((ph >= 5) && aluop));
        v[6] = act && (ph == 7) && (op == 6);
        v[5] = act && ((ph == 2) || (ph == 3));
        v[4] = act && (ph == 7) && aluop;
        v[3] = act && ((ph == 4) || ((ph == 6) && (op == 1) && z));
        v[2] = act && (ph >= 6) && (op == 7);
        v[1] = act && (ph >= 6) && (op == 6);
        v[0] = hlt || ((ph == 4) && (op == 0));
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        logic [8:0] got;
        got = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};
        chk({tag, "_phase"}, 32'(phase), 32'(m_phase));
        chk({tag, "_ctrl"}, 32'(got), 32'(exp_ctrl(m_phase, int'(opcode), zero, m_halted)));
        chk({tag, "_rd_wr_excl"}, 32'(rd & wr), 32'd0);
        chk({tag, "_wr_needs_data_e"}, 32'(wr & ~data_e), 32'd0);
    endtask

    task automatic model_step();
        if (m_halted) begin
            m_phase = 4;
            m_halt_cnt++;
        end else if ((m_phase == 4) && (opcode == 3'd0)) begin
            m_halted = 1'b1;
            m_phase  = 4;
        end else begin
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    function automatic logic [2:0] pick_op();
        if ($urandom_range(0, 19) == 0) return 3'd0;
        return 3'($urandom_range(1, 7));
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit rnd, input logic [2:0] op, input logic z, input bit do_rst);
        if (rnd) begin
            if ((m_phase <= 2) && !m_halted) opcode = pick_op();
            zero = 1'($urandom_range(0, 1));
        end else begin
            opcode = op;
            zero   = z;
        end
        #1;
        check_outputs("run");
        if (do_rst) begin
            #1 rst_n = 1'b0;
            #1;
            m_phase    = 0;
            m_halted   = 1'b0;
            m_halt_cnt = 0;
            check_outputs("rst_async");
            @(negedge clk);
            #1;
            check_outputs("rst_hold");
            rst_n = 1'b1;
        end
        model_step();
        @(negedge clk);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_phase    = 0;
        m_halted   = 1'b0;
        m_halt_cnt = 0;
        rst_n      = 1'b0;
        opcode     = 3'd2;
        zero       = 1'b0;
        #3;
        check_outputs("reset");
        @(negedge clk);
        #1;
        check_outputs("reset_edge");
        rst_n = 1'b1;

        // free run ADD, then one cycle each of STO, SKZ z=1, SKZ z=0, JMP
        repeat (16) cycle(1'b0, 3'd2, 1'b0, 1'b0);
        repeat (8)  cycle(1'b0, 3'd6, 1'b0, 1'b0);
        repeat (8)  cycle(1'b0, 3'd1, 1'b1, 1'b0);
        repeat (8)  cycle(1'b0, 3'd1, 1'b0, 1'b0);
        repeat (8)  cycle(1'b0, 3'd7, 1'b0, 1'b0);

        // halt and park for 25+ cycles, then asynchronous reset
        repeat (30) cycle(1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 1'b0, 1'b1);

        // store interrupted by reset in phase 6
        for (int i = 0; i < 8; i++) begin
            if (m_phase != 6) cycle(1'b0, 3'd6, 1'b0, 1'b0);
        end
        chk("sto_reached_phase6", 32'(phase), 32'd6);
        cycle(1'b0, 3'd6, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 3'd5, 1'b0, 1'b0);

        // randomized run with sporadic resets and halts
        for (int i = 0; i < 3000; i++) begin
            cycle(1'b1, 3'd0, 1'b0, ($urandom_range(0, 59) == 0) || (m_halt_cnt >= 25));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
